// File: rtl/timestamp_uart_tx.sv
// Sends a snapshot of the calendar counters as "YYYY-MM-DD hh:mm:ss\r\n" over 8N1 UART.
// tx/busy/dropped are registered; the frame starts the cycle after the accepted trigger.
module timestamp_uart_tx #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115_200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        trigger,
  input  logic [5:0]  sec,
  input  logic [5:0]  min,
  input  logic [4:0]  hour,
  input  logic [4:0]  day,
  input  logic [3:0]  mon,
  input  logic [13:0] year,
  output logic        tx,
  output logic        busy,
  output logic        dropped
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BW-1:0] BAUD_MAX = BW'(DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [4:0]    idx_q, idx_d;
  logic [5:0]    sec_q, sec_d, min_q, min_d;
  logic [4:0]    hour_q, hour_d, day_q, day_d;
  logic [3:0]    mon_q, mon_d;
  logic [13:0]   year_q, year_d;
  logic          tx_q, tx_d, busy_q, busy_d, dropped_q, dropped_d;
  logic          baud_end;
  logic [7:0]    cur_byte;
  logic [13:0]   ys, y_th, y_hu, y_te, y_on;

  function automatic logic [7:0] asc(input logic [3:0] d);
    return 8'h30 + {4'h0, d};
  endfunction

  function automatic logic [7:0] tens(input logic [5:0] v);
    logic [5:0] t;
    t = v / 6'd10;
    return asc(t[3:0]);
  endfunction

  function automatic logic [7:0] ones(input logic [5:0] v);
    logic [5:0] t;
    t = v % 6'd10;
    return asc(t[3:0]);
  endfunction

  assign baud_end = (baud_q == BAUD_MAX);

  // Year is clamped to four digits before splitting into decimal digits.
  always_comb begin
    ys   = (year_q > 14'd9999) ? 14'd9999 : year_q;
    y_th = ys / 14'd1000;
    y_hu = (ys / 14'd100) % 14'd10;
    y_te = (ys / 14'd10) % 14'd10;
    y_on = ys % 14'd10;
  end

  always_comb begin
    cur_byte = 8'h00;
    case (idx_q)
      5'd0:  cur_byte = asc(y_th[3:0]);
      5'd1:  cur_byte = asc(y_hu[3:0]);
      5'd2:  cur_byte = asc(y_te[3:0]);
      5'd3:  cur_byte = asc(y_on[3:0]);
      5'd4:  cur_byte = 8'h2D;
      5'd5:  cur_byte = tens({2'b00, mon_q});
      5'd6:  cur_byte = ones({2'b00, mon_q});
      5'd7:  cur_byte = 8'h2D;
      5'd8:  cur_byte = tens({1'b0, day_q});
      5'd9:  cur_byte = ones({1'b0, day_q});
      5'd10: cur_byte = 8'h20;
      5'd11: cur_byte = tens({1'b0, hour_q});
      5'd12: cur_byte = ones({1'b0, hour_q});
      5'd13: cur_byte = 8'h3A;
      5'd14: cur_byte = tens(min_q);
      5'd15: cur_byte = ones(min_q);
      5'd16: cur_byte = 8'h3A;
      5'd17: cur_byte = tens(sec_q);
      5'd18: cur_byte = ones(sec_q);
      5'd19: cur_byte = 8'h0D;
      5'd20: cur_byte = 8'h0A;
      default: cur_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    idx_d     = idx_q;
    sec_d     = sec_q;
    min_d     = min_q;
    hour_d    = hour_q;
    day_d     = day_q;
    mon_d     = mon_q;
    year_d    = year_q;
    dropped_d = trigger && (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        if (trigger) begin
          sec_d   = sec;
          min_d   = min;
          hour_d  = hour;
          day_d   = day;
          mon_d   = mon;
          year_d  = year;
          idx_d   = 5'd0;
          baud_d  = '0;
          state_d = START;
        end
      end
      START: begin
        baud_d = baud_end ? '0 : baud_q + BW'(1);
        if (baud_end) begin
          bit_d   = 3'd0;
          state_d = DATA;
        end
      end
      DATA: begin
        baud_d = baud_end ? '0 : baud_q + BW'(1);
        if (baud_end) begin
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      STOP: begin
        baud_d = baud_end ? '0 : baud_q + BW'(1);
        if (baud_end) begin
          if (idx_q == 5'd20) begin
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 5'd1;
            state_d = START;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Line level follows the state being entered so tx lines up with busy.
    busy_d = (state_d != IDLE);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = cur_byte[bit_d];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_q     <= 3'd0;
      idx_q     <= 5'd0;
      sec_q     <= 6'd0;
      min_q     <= 6'd0;
      hour_q    <= 5'd0;
      day_q     <= 5'd0;
      mon_q     <= 4'd0;
      year_q    <= 14'd0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      idx_q     <= idx_d;
      sec_q     <= sec_d;
      min_q     <= min_d;
      hour_q    <= hour_d;
      day_q     <= day_d;
      mon_q     <= mon_d;
      year_q    <= year_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      dropped_q <= dropped_d;
    end
  end

  assign tx      = tx_q;
  assign busy    = busy_q;
  assign dropped = dropped_q;

endmodule
